// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between the fetch_b stage and decode.
//
// Captures each non-bubble fetch_b slot {pc, instr, exc} and presents one
// registered instruction per cycle to decode. An empty queue is bypassed, so
// the fetch-to-decode latency is one cycle. Fetch is throttled through
// fetch_stall early enough that the two fetches already in flight still fit.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clk_en            global enable; low freezes every register
//   stall             decode stall; output registers hold, enqueue continues
//   flush             redirect; drops queued and incoming instructions
//   bubble_in         fetch_b slot empty
//   pc_in, exc_in     fetch_b pc and exception code (0 = none)
//   instr_in          memory read data for pc_in, same cycle
//   fetch_stall       stall request to fetch_a/fetch_b (from count only)
//   bubble_out        registered: no instruction for decode
//   pc_out, instr_out, exc_out  registered instruction to decode
//   overflow          sticky: enqueue attempted while full
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        bubble_in,
  input  logic [31:0] pc_in,
  input  logic [7:0]  exc_in,
  input  logic [31:0] instr_in,
  output logic        fetch_stall,
  output logic        bubble_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [7:0]  exc_out,
  output logic        overflow
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  // Two free slots are kept for the fetch_a/fetch_b pair still in flight.
  localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(DEPTH - 2);

  // Entry layout: {pc[71:40], instr[39:8], exc[7:0]}
  logic [71:0]      mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             bubble_q, bubble_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [7:0]       exc_q, exc_d;
  logic             overflow_q, overflow_d;

  logic        enq, can_out, empty, full;
  logic        deq, bypass, enq_store, ovf_set;
  logic [71:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign enq     = clk_en & ~flush & ~bubble_in;
  assign can_out = clk_en & ~flush & ~stall;
  assign deq     = can_out & ~empty;
  assign bypass  = can_out & empty & enq;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign enq_store = enq & ~bypass & (~full | deq);
  assign ovf_set   = enq & ~bypass & full & ~deq;
  assign head      = mem_q[rd_ptr_q];

  assign fetch_stall = (count_q >= STALL_CNT);
  assign bubble_out  = bubble_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign exc_out     = exc_q;
  assign overflow    = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    bubble_d   = bubble_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    exc_d      = exc_q;
    overflow_d = overflow_q | ovf_set;

    if (clk_en) begin
      if (flush) begin
        count_d  = '0;
        rd_ptr_d = wr_ptr_q;
        bubble_d = 1'b1;
      end else begin
        if (enq_store) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (deq)       rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({enq_store, deq})
          2'b10:   count_d = count_q + (PTR_W+1)'(1);
          2'b01:   count_d = count_q - (PTR_W+1)'(1);
          default: count_d = count_q;
        endcase

        // Excepting entries reach decode as a NOP carrying the code.
        if (deq) begin
          bubble_d = 1'b0;
          pc_d     = head[71:40];
          instr_d  = (head[7:0] != 8'd0) ? 32'd0 : head[39:8];
          exc_d    = head[7:0];
        end else if (bypass) begin
          bubble_d = 1'b0;
          pc_d     = pc_in;
          instr_d  = (exc_in != 8'd0) ? 32'd0 : instr_in;
          exc_d    = exc_in;
        end else if (!stall) begin
          // Empty queue and nothing arriving: keep the old payload visible.
          bubble_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      bubble_q   <= 1'b1;
      pc_q       <= '0;
      instr_q    <= '0;
      exc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      bubble_q   <= bubble_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      exc_q      <= exc_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (enq_store) mem_q[wr_ptr_q] <= {pc_in, instr_in, exc_in};
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        bubble_in = 1'b1;
  logic [31:0] pc_in = '0;
  logic [7:0]  exc_in = '0;
  logic [31:0] instr_in = '0;
  logic        fetch_stall, bubble_out, overflow;
  logic [31:0] pc_out, instr_out;
  logic [7:0]  exc_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall), .flush(flush),
    .bubble_in(bubble_in), .pc_in(pc_in), .exc_in(exc_in), .instr_in(instr_in),
    .fetch_stall(fetch_stall), .bubble_out(bubble_out), .pc_out(pc_out),
    .instr_out(instr_out), .exc_out(exc_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  exc;
  } entry_t;

  entry_t      q[$];
  logic        m_bub = 1'b1;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [7:0]  m_exc = '0;
  logic        m_ovf = 1'b0;

  task automatic present(input entry_t e);
    m_bub   = 1'b0;
    m_pc    = e.pc;
    m_instr = (e.exc != 8'd0) ? 32'd0 : e.instr;
    m_exc   = e.exc;
  endtask

  task automatic model_step();
    entry_t e, inc;
    inc.pc = pc_in; inc.instr = instr_in; inc.exc = exc_in;
    if (rst) begin
      q.delete();
      m_bub = 1'b1; m_pc = '0; m_instr = '0; m_exc = '0; m_ovf = 1'b0;
      return;
    end
    if (!clk_en) return;
    if (flush) begin
      q.delete();
      m_bub = 1'b1;
      return;
    end
    if (!stall) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        present(e);
        if (!bubble_in) q.push_back(inc);
      end else if (!bubble_in) begin
        present(inc);
      end else begin
        m_bub = 1'b1;
      end
    end else if (!bubble_in) begin
      if (q.size() < DEPTH) q.push_back(inc);
      else m_ovf = 1'b1;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("cmp_bubble", 32'(bubble_out), 32'(m_bub));
    check("cmp_pc", pc_out, m_pc);
    check("cmp_instr", instr_out, m_instr);
    check("cmp_exc", 32'(exc_out), 32'(m_exc));
    check("cmp_overflow", 32'(overflow), 32'(m_ovf));
    check("cmp_fetch_stall", 32'(fetch_stall), 32'(q.size() >= DEPTH - 2));
  endtask

  always @(negedge clk) if (chk_en) compare();

  // ---------------- stimulus ----------------
  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic step(input logic bub, input logic [31:0] pc, input logic [7:0] exc,
                      input logic [31:0] ins, input logic stl, input logic fl,
                      input logic en);
    bubble_in = bub; pc_in = pc; exc_in = exc; instr_in = ins;
    stall = stl; flush = fl; clk_en = en;
    @(negedge clk);
    $display("txn t=%0t bub_in=%0b pc_in=%h stall=%0b flush=%0b en=%0b -> bub_out=%0b pc_out=%h instr_out=%h exc_out=%h fstall=%0b ovf=%0b",
             $time, bub, pc, stl, fl, en, bubble_out, pc_out, instr_out, exc_out, fetch_stall, overflow);
  endtask

  task automatic send(input logic [31:0] pc, input logic stl);
    step(1'b0, pc, 8'd0, ins_of(pc), stl, 1'b0, 1'b1);
  endtask

  task automatic idle(input logic stl);
    step(1'b1, 32'd0, 8'd0, 32'd0, stl, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_bubble", 32'(bubble_out), 32'd1);
    check("rst_pc", pc_out, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_fetch_stall", 32'(fetch_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Streaming: bypass path, one-cycle latency, never stalls fetch
    for (int i = 0; i < 8; i++) begin
      send(32'h400 + 32'(4 * i), 1'b0);
      check("stream_pc", pc_out, 32'h400 + 32'(4 * i));
      check("stream_bubble", 32'(bubble_out), 32'd0);
      check("stream_fstall", 32'(fetch_stall), 32'd0);
    end
    idle(1'b0);
    check("stream_end_bubble", 32'(bubble_out), 32'd1);
    check("stream_end_pc_hold", pc_out, 32'h41C);

    // Stall absorb
    send(32'h400, 1'b0);
    send(32'h404, 1'b1);
    check("absorb_fstall_c1", 32'(fetch_stall), 32'd0);
    send(32'h408, 1'b1);
    check("absorb_fstall_c2", 32'(fetch_stall), 32'd1);
    send(32'h40C, 1'b1);
    idle(1'b1);
    check("absorb_hold_pc", pc_out, 32'h400);
    check("absorb_overflow", 32'(overflow), 32'd0);
    idle(1'b0);
    check("drain_pc0", pc_out, 32'h404);
    check("drain_fstall0", 32'(fetch_stall), 32'd1);
    idle(1'b0);
    check("drain_pc1", pc_out, 32'h408);
    check("drain_fstall1", 32'(fetch_stall), 32'd0);
    idle(1'b0);
    check("drain_pc2", pc_out, 32'h40C);
    check("drain_bubble2", 32'(bubble_out), 32'd0);
    idle(1'b0);
    check("drain_empty", 32'(bubble_out), 32'd1);

    // Flush with 3 entries queued, flush together with stall
    send(32'h500, 1'b0);
    send(32'h504, 1'b1);
    send(32'h508, 1'b1);
    send(32'h50C, 1'b1);
    step(1'b0, 32'h510, 8'd0, ins_of(32'h510), 1'b1, 1'b1, 1'b1);
    check("flush_bubble", 32'(bubble_out), 32'd1);
    check("flush_fstall", 32'(fetch_stall), 32'd0);
    check("flush_pc_hold", pc_out, 32'h500);
    send(32'h800, 1'b0);
    check("post_flush_pc", pc_out, 32'h800);
    check("post_flush_bubble", 32'(bubble_out), 32'd0);

    // Exception via bypass, then via the queue
    step(1'b0, 32'h402, 8'h84, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
    check("exc_pc", pc_out, 32'h402);
    check("exc_code", 32'(exc_out), 32'h84);
    check("exc_instr_nop", instr_out, 32'd0);
    check("exc_bubble", 32'(bubble_out), 32'd0);
    step(1'b0, 32'h700, 8'h11, 32'h12345678, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    check("qexc_pc", pc_out, 32'h700);
    check("qexc_code", 32'(exc_out), 32'h11);
    check("qexc_instr_nop", instr_out, 32'd0);
    idle(1'b0);
    check("qexc_empty", 32'(bubble_out), 32'd1);

    // Boundary: full queue with simultaneous enq/deq, then overflow
    for (int i = 0; i < 4; i++) send(32'h900 + 32'(4 * i), 1'b1);
    check("full_fstall", 32'(fetch_stall), 32'd1);
    send(32'h910, 1'b0);
    check("full_swap_pc", pc_out, 32'h900);
    check("full_swap_ovf", 32'(overflow), 32'd0);
    send(32'h914, 1'b1);
    check("overflow_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check("full_drain_pc", pc_out, 32'h904 + 32'(4 * i));
    end
    idle(1'b0);
    check("full_drain_empty", 32'(bubble_out), 32'd1);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // clk_en low freezes everything, then async reset mid-cycle
    send(32'hA00, 1'b1);
    send(32'hA04, 1'b1);
    step(1'b0, 32'hA08, 8'd0, ins_of(32'hA08), 1'b0, 1'b1, 1'b0);
    check("clken_hold_fstall", 32'(fetch_stall), 32'd1);
    check("clken_hold_bubble", 32'(bubble_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_bubble", 32'(bubble_out), 32'd1);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_fstall", 32'(fetch_stall), 32'd0);
    check("arst_pc", pc_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      check("post_rst_bubble", 32'(bubble_out), 32'd1);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the two-stage fetch pipe and decode.
- Captures each fetch_b result (pc, exc, bubble) with the instruction word returned by the 2-cycle memory in the same cycle.
- Absorbs in-flight fetches while decode stalls and presents one registered instruction per cycle to decode.
- Generates the fetch-side stall so no fetched instruction is lost.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 4.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous reset, active-high.
- clk_en  input  1  global clock enable; when low, no state changes.
- stall  input  1  decode/hazard stall; output registers hold.
- flush  input  1  branch/interrupt redirect; discard all queued and incoming instructions.
- bubble_in  input  1  fetch_b bubble flag; 1 means the slot is empty.
- pc_in  input  32  fetch_b pc.
- exc_in  input  8  fetch_b exception code; 0 means none.
- instr_in  input  32  memory read data for pc_in; valid in the same cycle as fetch_b outputs.
- fetch_stall  output  1  stall request to fetch_a/fetch_b.
- bubble_out  output  1  registered; 1 means no instruction to decode.
- pc_out  output  32  registered pc to decode.
- instr_out  output  32  registered instruction to decode.
- exc_out  output  8  registered exception code to decode.
- overflow  output  1  sticky error flag; set when an enqueue is attempted while full.

Behaviour:
- Reset (async, rst=1):
  - rd_ptr=wr_ptr=0, count=0.
  - bubble_out=1; pc_out, instr_out and exc_out = 0.
  - overflow=0.
- clk_en=0: every register holds, including while flush or stall is high.
- Enqueue condition: clk_en & !flush & !bubble_in. Stores {pc_in, instr_in, exc_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Dequeue condition: clk_en & !flush & !stall & (count>0).
  - Head entry loads the output registers with bubble_out=0; rd_ptr wraps.
  - Any entry with exc != 0 loads instr_out=0 (NOP) and exc_out=exc.
- Bypass: clk_en & !flush & !stall & count==0 & enqueue.
  - Incoming word loads the output registers directly, bubble_out=0.
  - No entry is written. Latency from fetch_b output to decode input is 1 cycle.
- clk_en & !flush & !stall & count==0 & no enqueue: bubble_out<=1; pc_out, instr_out and exc_out hold their previous values.
- stall=1 (no flush):
  - Output registers hold.
  - Enqueue still permitted, so in-flight fetches are captured.
- Simultaneous enqueue and dequeue: allowed at any count, including count==DEPTH. count is unchanged; the new entry goes to the tail.
- Ordering: strict FIFO. A bypass happens only when the queue is empty.
- count update is count + enq_stored - deq; count never exceeds DEPTH or drops below 0.
- Full case: enqueue with count==DEPTH and no same-cycle dequeue → entry dropped, overflow<=1 (sticky until reset). This is a design error the bench must never provoke in legal operation.
- fetch_stall = (DEPTH - count) <= 2, combinational from count only.
  - Headroom of 2 covers the fetch_a→fetch_b pair already in flight when fetch stalls.
  - With DEPTH=4: asserted when count >= 2.
- flush (clk_en=1), has priority over stall and enqueue:
  - count<=0; rd_ptr<=wr_ptr.
  - bubble_out<=1; pc_out, instr_out and exc_out hold.
  - Incoming word discarded.
  - fetch_stall deasserts the cycle after the flush.
- Reset mid-operation: immediate (async) return to reset values; queue contents lost.
- Width rules: pointers PTR_W bits, count PTR_W+1 bits; no other arithmetic.

Test Plan:
- Streaming: reset, then 8 consecutive non-bubble inputs with pc 0x400, 0x404, … and stall=0. Required: bubble_out=0 from the cycle after the first input; pc_out follows 1 cycle later; count stays 0; fetch_stall=0 throughout.
- Stall absorb: stream pcs 0x400–0x40C, hold stall=1 for 4 cycles while 3 more words arrive. Required: outputs hold pc 0x400; fetch_stall=1 once count reaches 2; overflow=0. After release, pcs 0x404, 0x408, … drain in order with no gaps or duplicates.
- Flush: queue holds 3 entries and flush=1 together with stall=1. Required: next cycle bubble_out=1, count=0, fetch_stall=0. A new pc 0x800 input the following cycle appears at pc_out 1 cycle later.
- Exception entry: input pc=0x402, exc_in=0x84, instr_in=0xDEADBEEF. Required: pc_out=0x402, exc_out=0x84, instr_out=0, bubble_out=0.
- Boundary: fill to count=4 with stall=1, then one enqueue with stall=0 in the same cycle. Required: count stays 4, order preserved, overflow=0. A second enqueue at count=4 with stall=1 sets overflow=1.
- Async reset with 2 entries queued and clk_en=0. Required: immediate bubble_out=1, overflow=0, fetch_stall=0; nothing dequeued afterwards.
